keypad_scanner: RTL

4x4 matrix keypad scanner for the guess-number game: the input-side counterpart of the row-scanned dot-matrix output. It drives one keypad column low at a time and samples the four row lines. It debounces over whole scan frames and emits a one-cycle `key_valid` strobe with a 4-bit hex key code per debounced press. It sits between the board keypad pins and the game controller, clocked by the same divided scan clock as the display driver.

---
 rtl/keypad_pkg.sv | 37 +++
 rtl/keypad_frame_scan.sv | 94 +++++++++
 rtl/keypad_scanner.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Brief    : Shared types and constants for the 4x4 keypad scanner.
// Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } scan_state_t;

    typedef enum logic [1:0] {
        FR_NONE  = 2'd0,
        FR_HIT   = 2'd1,
        FR_MULTI = 2'd2
    } frame_result_t;

    localparam int c_frame_len = 16;

    // Indexed by {row, col}; entry 0 is row 0 / col 0 ('1').
    localparam logic [15:0][3:0] c_key_map = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        return c_key_map[{row, col}];
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_frame_scan.sv
`default_nettype none
// ============================================================================
// Module   : keypad_frame_scan
// Brief    : Row synchronizer, column drive and per-frame hit/multi detection.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_frame_scan
    import keypad_pkg::*;
(
    input  logic       clk_div,
    input  logic       rst,
    input  logic [3:0] keypad_row,
    output logic [3:0] keypad_col,
    output logic       frame_end,
    output logic [1:0] frame_result,
    output logic [3:0] frame_code
);

    logic [3:0] r_row_meta;
    logic [3:0] r_row_sync;
    logic [1:0] r_phase;
    logic [1:0] r_col_idx;
    logic [1:0] r_low_cnt;
    logic [3:0] r_code;

    logic       w_sample;
    logic [3:0] w_low;
    logic [2:0] w_col_lows;
    logic [1:0] w_row_idx;
    logic [2:0] w_sum;
    logic [1:0] w_low_total;
    logic [3:0] w_code_next;

    always_ff @(posedge clk_div or negedge rst) begin
        if (!rst) begin
            r_row_meta <= 4'b1111;
            r_row_sync <= 4'b1111;
            r_phase    <= 2'd0;
            r_col_idx  <= 2'd0;
            r_low_cnt  <= 2'd0;
            r_code     <= 4'h0;
        end else begin
            r_row_meta <= keypad_row;
            r_row_sync <= r_row_meta;
            r_phase    <= r_phase + 2'd1;
            if (r_phase == 2'd3) begin
                r_col_idx <= r_col_idx + 2'd1;
            end
            if (frame_end) begin
                r_low_cnt <= 2'd0;
                r_code    <= 4'h0;
            end else if (w_sample) begin
                r_low_cnt <= w_low_total;
                r_code    <= w_code_next;
            end
        end
    end

    always_comb begin
        w_sample   = (r_phase == 2'd3);
        w_low      = ~r_row_sync;
        w_col_lows = 3'd0;
        w_row_idx  = 2'd0;
        if (w_sample) begin
            for (int i = 0; i < 4; i++) begin
                if (w_low[i]) begin
                    w_col_lows = w_col_lows + 3'd1;
                    w_row_idx  = 2'(i);
                end
            end
        end

        // Low count saturates at 2: anything beyond one low sample is a multi frame.
        w_sum       = {1'b0, r_low_cnt} + w_col_lows;
        w_low_total = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];

        w_code_next = r_code;
        if ((r_low_cnt == 2'd0) && (w_col_lows == 3'd1)) begin
            w_code_next = key_lookup(w_row_idx, r_col_idx);
        end

        frame_end  = ({r_col_idx, r_phase} == 4'(c_frame_len - 1));
        frame_code = w_code_next;
        case (w_low_total)
            2'd0:    frame_result = FR_NONE;
            2'd1:    frame_result = FR_HIT;
            default: frame_result = FR_MULTI;
        endcase

        keypad_col = ~(4'b0001 << r_col_idx);
    end

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Brief    : 4x4 keypad scanner with frame-level debounce and key strobe.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
)
(
    input  logic       clk_div,
    input  logic       rst,
    input  logic [3:0] keypad_row,
    output logic [3:0] keypad_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam logic [2:0] c_debounce = 3'(DEBOUNCE_SCANS);

    logic        w_frame_end;
    logic [1:0]  w_frame_result;
    logic [3:0]  w_frame_code;

    scan_state_t r_state;
    scan_state_t w_state_next;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_next;
    logic [2:0]  w_cnt_inc;
    logic [3:0]  r_cand;
    logic [3:0]  w_cand_next;
    logic [3:0]  r_key_code;
    logic [3:0]  w_key_code_next;
    logic        r_key_valid;
    logic        w_key_valid_next;
    logic        r_key_held;
    logic        w_key_held_next;
    logic        w_hit;
    logic        w_none;
    logic        w_accept;

    keypad_frame_scan u_frame_scan (
        .clk_div      (clk_div),
        .rst          (rst),
        .keypad_row   (keypad_row),
        .keypad_col   (keypad_col),
        .frame_end    (w_frame_end),
        .frame_result (w_frame_result),
        .frame_code   (w_frame_code)
    );

    always_ff @(posedge clk_div or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 3'd0;
            r_cand      <= 4'h0;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_cand      <= w_cand_next;
            r_key_code  <= w_key_code_next;
            r_key_valid <= w_key_valid_next;
            r_key_held  <= w_key_held_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_cand_next      = r_cand;
        w_key_code_next  = r_key_code;
        w_key_valid_next = 1'b0;
        w_accept         = 1'b0;
        w_cnt_inc        = r_cnt + 3'd1;
        w_hit            = (w_frame_result == FR_HIT);
        w_none           = (w_frame_result == FR_NONE);

        // Decisions are made only on whole frames; mid-frame cycles just hold.
        if (w_frame_end) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hit) begin
                        w_cand_next = w_frame_code;
                        w_cnt_next  = 3'd1;
                        if (c_debounce == 3'd1) begin
                            w_state_next = ST_PRESSED;
                            w_accept     = 1'b1;
                        end else begin
                            w_state_next = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_hit) begin
                        if (w_frame_code == r_cand) begin
                            w_cnt_next = w_cnt_inc;
                            if (w_cnt_inc == c_debounce) begin
                                w_state_next = ST_PRESSED;
                                w_accept     = 1'b1;
                            end
                        end else begin
                            w_cand_next = w_frame_code;
                            w_cnt_next  = 3'd1;
                        end
                    end else begin
                        w_state_next = ST_IDLE;
                        w_cnt_next   = 3'd0;
                    end
                end
                ST_PRESSED: begin
                    if (w_none) begin
                        if (c_debounce == 3'd1) begin
                            w_state_next = ST_IDLE;
                            w_cnt_next   = 3'd0;
                        end else begin
                            w_state_next = ST_RELEASE;
                            w_cnt_next   = 3'd1;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (w_none) begin
                        w_cnt_next = w_cnt_inc;
                        if (w_cnt_inc == c_debounce) begin
                            w_state_next = ST_IDLE;
                            w_cnt_next   = 3'd0;
                        end
                    end else begin
                        w_state_next = ST_PRESSED;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = 3'd0;
                end
            endcase
        end

        if (w_accept) begin
            w_key_code_next  = w_cand_next;
            w_key_valid_next = 1'b1;
        end

        w_key_held_next = (w_state_next == ST_PRESSED) || (w_state_next == ST_RELEASE);
    end

    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule
`default_nettype wire
